// File: rtl/rs_alu_dispatch_pkg.sv
// Shared ALU opcode encoding and default ROB/RS widths for the decoder, ALU and reservation station.
package rs_alu_dispatch_pkg;

  localparam int unsigned ROB_WIDTH_DEF = 4;
  localparam int unsigned RS_WIDTH_DEF  = 3;
  localparam int unsigned XLEN          = 32;
  localparam int unsigned OP_W          = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 4'd0,
    OP_LUI   = 4'd1,
    OP_AUIPC = 4'd2,
    OP_JAL   = 4'd3,
    OP_ADD   = 4'd4,
    OP_SUB   = 4'd5,
    OP_AND   = 4'd6,
    OP_OR    = 4'd7,
    OP_XOR   = 4'd8,
    OP_SLL   = 4'd9,
    OP_SRL   = 4'd10,
    OP_SRA   = 4'd11,
    OP_SLT   = 4'd12,
    OP_SLTU  = 4'd13,
    OP_BR    = 4'd14,
    OP_JALR  = 4'd15
  } alu_op_e;

endpackage

// File: rtl/rs_priority_select.sv
// Lowest-index set-bit finder; reports whether any request is set and the index of the first one.
module rs_priority_select #(
  parameter int unsigned N  = 8,
  parameter int unsigned IW = 3
) (
  input  logic [N-1:0]  req,
  output logic          found_c,
  output logic [IW-1:0] idx_c
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found_c = 1'b1;
        idx_c   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/rs_alu_dispatch.sv
// ALU reservation station: buffers issued ops, snoops ALU/LSB result buses, dispatches one ready op per cycle.
// Optional RS_ISSUE_BYPASS_EN lets a fully ready issuing op go straight to the ALU when nothing stored is ready.
module rs_alu_dispatch
  import rs_alu_dispatch_pkg::*;
#(
  parameter int unsigned ROB_WIDTH = ROB_WIDTH_DEF,
  parameter int unsigned RS_WIDTH  = RS_WIDTH_DEF
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear_signal,
  input  logic                 issue_signal,
  input  logic [OP_W-1:0]      issue_opcode,
  input  logic [XLEN-1:0]      issue_vj,
  input  logic [ROB_WIDTH-1:0] issue_qj,
  input  logic                 issue_rj,
  input  logic [XLEN-1:0]      issue_vk,
  input  logic [ROB_WIDTH-1:0] issue_qk,
  input  logic                 issue_rk,
  input  logic [ROB_WIDTH-1:0] issue_tag,
  output logic                 rs_full,
  input  logic                 alu_done,
  input  logic [XLEN-1:0]      alu_value,
  input  logic [ROB_WIDTH-1:0] alu_tag,
  input  logic                 lsb_done,
  input  logic [XLEN-1:0]      lsb_value,
  input  logic [ROB_WIDTH-1:0] lsb_tag,
  output logic                 cal_signal,
  output logic [OP_W-1:0]      opcode,
  output logic [XLEN-1:0]      lhs,
  output logic [XLEN-1:0]      rhs,
  output logic [ROB_WIDTH-1:0] tag
);

  localparam int unsigned RS_SIZE = 1 << RS_WIDTH;

  typedef struct packed {
    logic                 busy;
    alu_op_e              op;
    logic [XLEN-1:0]      vj;
    logic [ROB_WIDTH-1:0] qj;
    logic                 rj;
    logic [XLEN-1:0]      vk;
    logic [ROB_WIDTH-1:0] qk;
    logic                 rk;
    logic [ROB_WIDTH-1:0] dest;
  } entry_t;

  entry_t ent_q [RS_SIZE];
  entry_t ent_d [RS_SIZE];

  logic [RS_SIZE-1:0]  free_vec;
  logic [RS_SIZE-1:0]  ready_vec;
  logic                free_found;
  logic                sel_found;
  logic [RS_WIDTH-1:0] free_idx;
  logic [RS_WIDTH-1:0] sel_idx;
  logic                in_rj;
  logic                in_rk;
  logic [XLEN-1:0]     in_vj;
  logic [XLEN-1:0]     in_vk;
  logic                bypass;
  logic                do_alloc;

  function automatic logic alu_hit(input logic [ROB_WIDTH-1:0] q);
    return alu_done && (alu_tag == q);
  endfunction

  function automatic logic lsb_hit(input logic [ROB_WIDTH-1:0] q);
    return lsb_done && (lsb_tag == q);
  endfunction

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      free_vec[i]  = ~ent_q[i].busy;
      ready_vec[i] = ent_q[i].busy & ent_q[i].rj & ent_q[i].rk;
    end
  end

  rs_priority_select #(.N(RS_SIZE), .IW(RS_WIDTH)) u_free_sel (
    .req     (free_vec),
    .found_c (free_found),
    .idx_c   (free_idx)
  );

  rs_priority_select #(.N(RS_SIZE), .IW(RS_WIDTH)) u_ready_sel (
    .req     (ready_vec),
    .found_c (sel_found),
    .idx_c   (sel_idx)
  );

  assign rs_full = ~free_found;

  // Same-cycle broadcast forwarding for the incoming operands.
  always_comb begin
    in_rj = issue_rj;
    in_vj = issue_vj;
    in_rk = issue_rk;
    in_vk = issue_vk;
    if (!issue_rj && alu_hit(issue_qj)) begin
      in_rj = 1'b1;
      in_vj = alu_value;
    end else if (!issue_rj && lsb_hit(issue_qj)) begin
      in_rj = 1'b1;
      in_vj = lsb_value;
    end
    if (!issue_rk && alu_hit(issue_qk)) begin
      in_rk = 1'b1;
      in_vk = alu_value;
    end else if (!issue_rk && lsb_hit(issue_qk)) begin
      in_rk = 1'b1;
      in_vk = lsb_value;
    end
  end

`ifdef RS_ISSUE_BYPASS_EN
  assign bypass = issue_signal & free_found & in_rj & in_rk & ~sel_found;
`else
  assign bypass = 1'b0;
`endif

  assign do_alloc = issue_signal & free_found & ~bypass;

  // Next entry state: snoop, retire the dispatched entry, allocate the issue.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].busy && !ent_q[i].rj) begin
        if (alu_hit(ent_q[i].qj)) begin
          ent_d[i].rj = 1'b1;
          ent_d[i].vj = alu_value;
        end else if (lsb_hit(ent_q[i].qj)) begin
          ent_d[i].rj = 1'b1;
          ent_d[i].vj = lsb_value;
        end
      end
      if (ent_q[i].busy && !ent_q[i].rk) begin
        if (alu_hit(ent_q[i].qk)) begin
          ent_d[i].rk = 1'b1;
          ent_d[i].vk = alu_value;
        end else if (lsb_hit(ent_q[i].qk)) begin
          ent_d[i].rk = 1'b1;
          ent_d[i].vk = lsb_value;
        end
      end
    end
    if (sel_found) begin
      ent_d[sel_idx].busy = 1'b0;
    end
    if (do_alloc) begin
      ent_d[free_idx].busy = 1'b1;
      ent_d[free_idx].op   = alu_op_e'(issue_opcode);
      ent_d[free_idx].vj   = in_vj;
      ent_d[free_idx].qj   = issue_qj;
      ent_d[free_idx].rj   = in_rj;
      ent_d[free_idx].vk   = in_vk;
      ent_d[free_idx].qk   = issue_qk;
      ent_d[free_idx].rk   = in_rk;
      ent_d[free_idx].dest = issue_tag;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i].busy <= 1'b0;
      cal_signal <= 1'b0;
      opcode     <= '0;
      lhs        <= '0;
      rhs        <= '0;
      tag        <= '0;
    end else if (rdy_in) begin
      if (clear_signal) begin
        for (int i = 0; i < RS_SIZE; i++) ent_q[i].busy <= 1'b0;
        cal_signal <= 1'b0;
      end else begin
        ent_q <= ent_d;
        if (sel_found) begin
          cal_signal <= 1'b1;
          opcode     <= ent_q[sel_idx].op;
          lhs        <= ent_q[sel_idx].vj;
          rhs        <= ent_q[sel_idx].vk;
          tag        <= ent_q[sel_idx].dest;
        end else if (bypass) begin
          cal_signal <= 1'b1;
          opcode     <= issue_opcode;
          lhs        <= in_vj;
          rhs        <= in_vk;
          tag        <= issue_tag;
        end else begin
          cal_signal <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_alu_dispatch.sv
// Self-checking bench for rs_alu_dispatch: directed scenarios plus randomized traffic against a reference model.
module tb_rs_alu_dispatch;

`ifdef RS_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_signal, issue_signal;
  logic [3:0]  issue_opcode, issue_qj, issue_qk, issue_tag;
  logic [31:0] issue_vj, issue_vk;
  logic        issue_rj, issue_rk;
  logic        rs_full;
  logic        alu_done, lsb_done;
  logic [31:0] alu_value, lsb_value;
  logic [3:0]  alu_tag, lsb_tag;
  logic        cal_signal;
  logic [3:0]  opcode, tag;
  logic [31:0] lhs, rhs;

  int checks = 0;
  int errors = 0;

  rs_alu_dispatch dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_signal(clear_signal),
    .issue_signal(issue_signal), .issue_opcode(issue_opcode),
    .issue_vj(issue_vj), .issue_qj(issue_qj), .issue_rj(issue_rj),
    .issue_vk(issue_vk), .issue_qk(issue_qk), .issue_rk(issue_rk),
    .issue_tag(issue_tag), .rs_full(rs_full),
    .alu_done(alu_done), .alu_value(alu_value), .alu_tag(alu_tag),
    .lsb_done(lsb_done), .lsb_value(lsb_value), .lsb_tag(lsb_tag),
    .cal_signal(cal_signal), .opcode(opcode), .lhs(lhs), .rhs(rhs), .tag(tag)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: a slot table plus the expected output registers.
  logic        m_busy [8];
  logic [3:0]  m_op [8], m_qj [8], m_qk [8], m_dst [8];
  logic [31:0] m_vj [8], m_vk [8];
  logic        m_rj [8], m_rk [8];
  logic        m_cal = 1'b0;
  logic [3:0]  m_opcode = 4'd0, m_tag = 4'd0;
  logic [31:0] m_lhs = 32'd0, m_rhs = 32'd0;

  function automatic void fwd(input logic r, input logic [3:0] q, input logic [31:0] v,
                              output logic ro, output logic [31:0] vo);
    ro = r;
    vo = v;
    if (!r && alu_done && alu_tag == q) begin
      ro = 1'b1; vo = alu_value;
    end else if (!r && lsb_done && lsb_tag == q) begin
      ro = 1'b1; vo = lsb_value;
    end
  endfunction

  function automatic logic model_full();
    for (int i = 0; i < 8; i++) if (!m_busy[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_step();
    int sel, slot;
    logic irj, irk, byp, r;
    logic [31:0] ivj, ivk, v;
    if (rst_in) begin
      for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
      m_cal = 1'b0; m_opcode = 4'd0; m_lhs = 32'd0; m_rhs = 32'd0; m_tag = 4'd0;
      return;
    end
    if (!rdy_in) return;
    if (clear_signal) begin
      for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
      m_cal = 1'b0;
      return;
    end
    sel = -1;
    slot = -1;
    for (int i = 7; i >= 0; i--) begin
      if (m_busy[i] && m_rj[i] && m_rk[i]) sel = i;
      if (!m_busy[i]) slot = i;
    end
    fwd(issue_rj, issue_qj, issue_vj, irj, ivj);
    fwd(issue_rk, issue_qk, issue_vk, irk, ivk);
    for (int i = 0; i < 8; i++) begin
      if (m_busy[i]) begin
        fwd(m_rj[i], m_qj[i], m_vj[i], r, v); m_rj[i] = r; m_vj[i] = v;
        fwd(m_rk[i], m_qk[i], m_vk[i], r, v); m_rk[i] = r; m_vk[i] = v;
      end
    end
    byp = BYP && issue_signal && slot >= 0 && irj && irk && sel < 0;
    if (sel >= 0) begin
      m_cal = 1'b1; m_opcode = m_op[sel]; m_lhs = m_vj[sel]; m_rhs = m_vk[sel]; m_tag = m_dst[sel];
      m_busy[sel] = 1'b0;
    end else if (byp) begin
      m_cal = 1'b1; m_opcode = issue_opcode; m_lhs = ivj; m_rhs = ivk; m_tag = issue_tag;
    end else begin
      m_cal = 1'b0;
    end
    if (issue_signal && slot >= 0 && !byp) begin
      m_busy[slot] = 1'b1; m_op[slot] = issue_opcode; m_dst[slot] = issue_tag;
      m_vj[slot] = ivj; m_qj[slot] = issue_qj; m_rj[slot] = irj;
      m_vk[slot] = ivk; m_qk[slot] = issue_qk; m_rk[slot] = irk;
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    rst_in = 1'b0; rdy_in = 1'b1; clear_signal = 1'b0; issue_signal = 1'b0;
    alu_done = 1'b0; lsb_done = 1'b0;
  endtask

  task automatic set_issue(input logic [3:0] op, input logic [31:0] vj, input logic [3:0] qj, input logic rj,
                           input logic [31:0] vk, input logic [3:0] qk, input logic rk, input logic [3:0] t);
    issue_signal = 1'b1; issue_opcode = op; issue_tag = t;
    issue_vj = vj; issue_qj = qj; issue_rj = rj;
    issue_vk = vk; issue_qk = qk; issue_rk = rk;
  endtask

  task automatic test_reset();
    idle();
    rst_in = 1'b1;
    tick(); tick();
    idle();
    checks++; if (cal_signal !== 1'b0) begin errors++; $display("FAIL reset_cal: got %b expected 0", cal_signal); end
    checks++; if (opcode !== 4'd0) begin errors++; $display("FAIL reset_opcode: got %0h expected 0", opcode); end
    checks++; if (lhs !== 32'd0) begin errors++; $display("FAIL reset_lhs: got %0h expected 0", lhs); end
    checks++; if (rhs !== 32'd0) begin errors++; $display("FAIL reset_rhs: got %0h expected 0", rhs); end
    checks++; if (tag !== 4'd0) begin errors++; $display("FAIL reset_tag: got %0h expected 0", tag); end
    checks++; if (rs_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", rs_full); end
  endtask

  task automatic test_add_ready();
    set_issue(4'd4, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 1'b1, 4'd3);
    tick(); idle();
    checks++; if (cal_signal !== BYP) begin errors++; $display("FAIL add_e0_cal: got %b expected %b", cal_signal, BYP); end
    tick();
    checks++; if (cal_signal !== !BYP) begin errors++; $display("FAIL add_e1_cal: got %b expected %b", cal_signal, !BYP); end
    checks++; if (opcode !== 4'd4) begin errors++; $display("FAIL add_opcode: got %0h expected 4", opcode); end
    checks++; if (lhs !== 32'd5) begin errors++; $display("FAIL add_lhs: got %0h expected 5", lhs); end
    checks++; if (rhs !== 32'd7) begin errors++; $display("FAIL add_rhs: got %0h expected 7", rhs); end
    checks++; if (tag !== 4'd3) begin errors++; $display("FAIL add_tag: got %0h expected 3", tag); end
    tick();
    checks++; if (cal_signal !== 1'b0) begin errors++; $display("FAIL add_one_shot: got %b expected 0", cal_signal); end
  endtask

  task automatic test_snoop_alu();
    set_issue(4'd5, 32'd0, 4'd2, 1'b0, 32'd1, 4'd0, 1'b1, 4'd4);
    tick(); idle();
    tick();
    checks++; if (cal_signal !== 1'b0) begin errors++; $display("FAIL sub_wait: got %b expected 0", cal_signal); end
    alu_done = 1'b1; alu_tag = 4'd2; alu_value = 32'd10;
    tick(); idle();
    checks++; if (cal_signal !== 1'b0) begin errors++; $display("FAIL sub_bcast_edge: got %b expected 0", cal_signal); end
    tick();
    checks++; if (cal_signal !== 1'b1) begin errors++; $display("FAIL sub_dispatch: got %b expected 1", cal_signal); end
    checks++; if (lhs !== 32'd10) begin errors++; $display("FAIL sub_lhs: got %0h expected a", lhs); end
    checks++; if (rhs !== 32'd1) begin errors++; $display("FAIL sub_rhs: got %0h expected 1", rhs); end
    checks++; if (opcode !== 4'd5 || tag !== 4'd4) begin errors++; $display("FAIL sub_op_tag: got %0h/%0h expected 5/4", opcode, tag); end
    tick();
  endtask

  task automatic test_issue_forward();
    set_issue(4'd6, 32'd3, 4'd0, 1'b1, 32'd0, 4'd6, 1'b0, 4'd5);
    lsb_done = 1'b1; lsb_tag = 4'd6; lsb_value = 32'hFFFF_FFF0;
    tick(); idle();
    checks++; if (cal_signal !== BYP) begin errors++; $display("FAIL fwd_e0_cal: got %b expected %b", cal_signal, BYP); end
    tick();
    checks++; if (cal_signal !== !BYP) begin errors++; $display("FAIL fwd_e1_cal: got %b expected %b", cal_signal, !BYP); end
    checks++; if (rhs !== 32'hFFFF_FFF0) begin errors++; $display("FAIL fwd_rhs: got %0h expected fffffff0", rhs); end
    checks++; if (lhs !== 32'd3 || tag !== 4'd5) begin errors++; $display("FAIL fwd_lhs_tag: got %0h/%0h expected 3/5", lhs, tag); end
    tick();
  endtask

  task automatic test_full();
    clear_signal = 1'b1;
    tick(); idle();
    for (int i = 0; i < 8; i++) begin
      set_issue(4'(i), 32'd0, 4'(8 + i), 1'b0, 32'(i), 4'd0, 1'b1, 4'(i));
      tick(); idle();
      if (i == 6) begin
        checks++; if (rs_full !== 1'b0) begin errors++; $display("FAIL full_at7: got %b expected 0", rs_full); end
      end
    end
    checks++; if (rs_full !== 1'b1) begin errors++; $display("FAIL full_at8: got %b expected 1", rs_full); end
    set_issue(4'd4, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0, 1'b1, 4'd9);
    tick(); idle();
    checks++; if (cal_signal !== 1'b0 || rs_full !== 1'b1) begin errors++; $display("FAIL full_drop: got cal %b full %b expected 0 1", cal_signal, rs_full); end
    alu_done = 1'b1; alu_tag = 4'd8; alu_value = 32'd100;
    tick(); idle();
    checks++; if (cal_signal !== 1'b0 || rs_full !== 1'b1) begin errors++; $display("FAIL full_bcast: got cal %b full %b expected 0 1", cal_signal, rs_full); end
    tick();
    checks++; if (cal_signal !== 1'b1 || lhs !== 32'd100 || rhs !== 32'd0 || tag !== 4'd0) begin
      errors++; $display("FAIL full_dispatch: got cal %b lhs %0h rhs %0h tag %0h expected 1 64 0 0", cal_signal, lhs, rhs, tag);
    end
    checks++; if (rs_full !== 1'b0) begin errors++; $display("FAIL full_release: got %b expected 0", rs_full); end
    tick();
    checks++; if (cal_signal !== 1'b0) begin errors++; $display("FAIL full_dropped_stays_dropped: got %b expected 0", cal_signal); end
    clear_signal = 1'b1;
    tick(); idle();
  endtask

  task automatic test_clear();
    for (int i = 1; i <= 3; i++) begin
      set_issue(4'd7, 32'd0, 4'(i), 1'b0, 32'd9, 4'd0, 1'b1, 4'(i));
      tick(); idle();
    end
    set_issue(4'd4, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 1'b1, 4'd12);
    clear_signal = 1'b1;
    tick(); idle();
    checks++; if (cal_signal !== 1'b0 || rs_full !== 1'b0) begin errors++; $display("FAIL clear_state: got cal %b full %b expected 0 0", cal_signal, rs_full); end
    alu_done = 1'b1; alu_tag = 4'd1; alu_value = 32'd1;
    lsb_done = 1'b1; lsb_tag = 4'd2; lsb_value = 32'd2;
    tick(); idle();
    alu_done = 1'b1; alu_tag = 4'd3; alu_value = 32'd3;
    tick(); idle();
    checks++; if (cal_signal !== 1'b0) begin errors++; $display("FAIL clear_stale1: got %b expected 0", cal_signal); end
    tick();
    checks++; if (cal_signal !== 1'b0) begin errors++; $display("FAIL clear_stale2: got %b expected 0", cal_signal); end
  endtask

  task automatic test_rdy_hold();
    set_issue(4'd7, 32'd0, 4'd7, 1'b0, 32'd2, 4'd0, 1'b1, 4'd11);
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      rdy_in = 1'b0; alu_done = 1'b1; alu_tag = 4'd7; alu_value = 32'h55;
      tick();
      checks++; if (cal_signal !== 1'b0) begin errors++; $display("FAIL hold_wait%0d: got %b expected 0", i, cal_signal); end
    end
    idle();
    tick();
    checks++; if (cal_signal !== 1'b0) begin errors++; $display("FAIL hold_ignored_bcast: got %b expected 0", cal_signal); end
    alu_done = 1'b1; alu_tag = 4'd7; alu_value = 32'h77;
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      rdy_in = 1'b0; lsb_done = 1'b1; lsb_tag = 4'd7; lsb_value = 32'h99;
      tick();
      checks++; if (cal_signal !== 1'b0) begin errors++; $display("FAIL hold_ready%0d: got %b expected 0", i, cal_signal); end
    end
    idle();
    tick();
    checks++; if (cal_signal !== 1'b1 || lhs !== 32'h77 || tag !== 4'd11) begin
      errors++; $display("FAIL hold_resume: got cal %b lhs %0h tag %0h expected 1 77 b", cal_signal, lhs, tag);
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      idle();
      rdy_in       = ($urandom_range(0, 9) != 0);
      clear_signal = ($urandom_range(0, 49) == 0);
      issue_signal = 1'($urandom_range(0, 1));
      issue_opcode = 4'($urandom); issue_tag = 4'($urandom);
      issue_vj = $urandom; issue_qj = 4'($urandom); issue_rj = ($urandom_range(0, 2) == 0);
      issue_vk = $urandom; issue_qk = 4'($urandom); issue_rk = ($urandom_range(0, 2) == 0);
      alu_done = 1'($urandom_range(0, 1)); alu_tag = 4'($urandom); alu_value = $urandom;
      lsb_done = 1'($urandom_range(0, 1)); lsb_tag = alu_tag ^ 4'($urandom_range(1, 15)); lsb_value = $urandom;
      tick();
      checks++; if (cal_signal !== m_cal) begin errors++; $display("FAIL rand_cal @%0d: got %b expected %b", n, cal_signal, m_cal); end
      checks++; if (opcode !== m_opcode) begin errors++; $display("FAIL rand_opcode @%0d: got %0h expected %0h", n, opcode, m_opcode); end
      checks++; if (lhs !== m_lhs) begin errors++; $display("FAIL rand_lhs @%0d: got %0h expected %0h", n, lhs, m_lhs); end
      checks++; if (rhs !== m_rhs) begin errors++; $display("FAIL rand_rhs @%0d: got %0h expected %0h", n, rhs, m_rhs); end
      checks++; if (tag !== m_tag) begin errors++; $display("FAIL rand_tag @%0d: got %0h expected %0h", n, tag, m_tag); end
      checks++; if (rs_full !== model_full()) begin errors++; $display("FAIL rand_full @%0d: got %b expected %b", n, rs_full, model_full()); end
    end
    idle();
  endtask

  initial begin
    idle();
    issue_opcode = 4'd0; issue_tag = 4'd0; issue_vj = 32'd0; issue_qj = 4'd0; issue_rj = 1'b0;
    issue_vk = 32'd0; issue_qk = 4'd0; issue_rk = 1'b0;
    alu_value = 32'd0; alu_tag = 4'd0; lsb_value = 32'd0; lsb_tag = 4'd0;
    for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
    test_reset();
    test_add_ready();
    test_snoop_alu();
    test_issue_forward();
    test_full();
    test_clear();
    test_rdy_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
